pe_window_buffer: RTL and testbench

- Line-buffer and window generator that sits directly upstream of the binarized conv/pool PE.
- Accepts a raster-order stream of binary feature-map pixels, each D bits with one bit per channel.
- Emits one IN_WINDOW_H x IN_WINDOW_W pixel window per pooled output position, already flattened in the PE's data_in bit order.
- Uses valid/ready handshakes on both sides; no padding, valid-convolution only.

---
 rtl/pe_window_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_pe_window_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pe_window_buffer
// Purpose  : Line buffer and sliding-window generator feeding the binarized
//            conv/pool PE. Takes a raster-order stream of D-bit binary pixels
//            and emits one IN_WINDOW_H x IN_WINDOW_W window per pooled output
//            position, flattened in the PE's data_in bit order. Valid-only
//            convolution, no padding. Requires IN_WINDOW_H >= 2.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            in_valid   - pixel_in valid
//            in_ready   - pixel accepted when in_valid && in_ready
//            pixel_in   - one pixel, D channels, raster order
//            out_valid  - window_out holds a complete window
//            out_ready  - downstream consumes the window
//            window_out - flattened window, top-left pixel at the MSBs
//            out_last   - window is the last one of the frame
// Revision : 1.0 - initial release
// ============================================================================
module pe_window_buffer #(
  parameter  int D           = 512,
  parameter  int FH          = 3,
  parameter  int FW          = 3,
  parameter  int POOL_H      = 2,
  parameter  int POOL_W      = 2,
  parameter  int STRIDE_H    = 1,
  parameter  int STRIDE_W    = 1,
  parameter  int IMG_W       = 32,
  parameter  int IMG_H       = 32,
  localparam int IN_WINDOW_H = (POOL_H - 1) * STRIDE_H + FH,
  localparam int IN_WINDOW_W = (POOL_W - 1) * STRIDE_W + FW,
  localparam int STEP_H      = POOL_H * STRIDE_H,
  localparam int STEP_W      = POOL_W * STRIDE_W,
  localparam int OUT_WIDTH   = D * IN_WINDOW_H * IN_WINDOW_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [D-1:0]         pixel_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] window_out,
  output logic                 out_last
);

  localparam int CW  = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
  localparam int RW  = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
  localparam int PWW = (STEP_W > 1) ? $clog2(STEP_W) : 1;
  localparam int PWH = (STEP_H > 1) ? $clog2(STEP_H) : 1;

  localparam logic [CW-1:0]  C_COL_LAST       = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  C_ROW_LAST       = RW'(IMG_H - 1);
  localparam logic [CW-1:0]  C_COL_FIRST_EMIT = CW'(IN_WINDOW_W - 1);
  localparam logic [RW-1:0]  C_ROW_FIRST_EMIT = RW'(IN_WINDOW_H - 1);
  // Last position of the frame that lands on the emission grid.
  localparam logic [CW-1:0]  C_COL_LAST_EMIT  =
    CW'(IN_WINDOW_W - 1 + ((IMG_W - IN_WINDOW_W) / STEP_W) * STEP_W);
  localparam logic [RW-1:0]  C_ROW_LAST_EMIT  =
    RW'(IN_WINDOW_H - 1 + ((IMG_H - IN_WINDOW_H) / STEP_H) * STEP_H);
  localparam logic [PWW-1:0] C_PH_W_LAST      = PWW'(STEP_W - 1);
  localparam logic [PWH-1:0] C_PH_H_LAST      = PWH'(STEP_H - 1);

  // Position of the next pixel, plus phase counters tracking
  // (pos - first_emit_pos) mod STEP once past the first emitting position.
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [PWW-1:0] col_ph_q, col_ph_d;
  logic [PWH-1:0] row_ph_q, row_ph_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;

  logic [D-1:0]   win_q [IN_WINDOW_H][IN_WINDOW_W];
  logic [D-1:0]   win_d [IN_WINDOW_H][IN_WINDOW_W];
  logic [D-1:0]   lb_mem [IN_WINDOW_H-1][IMG_W];

  // Incoming right-hand column: line-buffer words at the current column for
  // the upper rows, the live pixel for the bottom row. Entry k+1 is also what
  // line buffer k takes next, so one vector serves both shifts.
  logic [D-1:0]   col_src [IN_WINDOW_H];

  logic                 accept;
  logic                 emit;
  logic                 is_last;
  logic [OUT_WIDTH-1:0] window_flat;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  generate
    for (genvar r = 0; r < IN_WINDOW_H - 1; r++) begin : g_lb_rd
      assign col_src[r] = lb_mem[r][col_q];
    end
  endgenerate
  assign col_src[IN_WINDOW_H-1] = pixel_in;

  assign emit = accept
             && (row_q >= C_ROW_FIRST_EMIT) && (col_q >= C_COL_FIRST_EMIT)
             && (row_ph_q == '0) && (col_ph_q == '0);
  assign is_last = (row_q == C_ROW_LAST_EMIT) && (col_q == C_COL_LAST_EMIT);

  // Counters and phases.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    if (accept) begin
      if (col_q == C_COL_LAST) begin
        col_d    = '0;
        col_ph_d = '0;
        if (row_q == C_ROW_LAST) begin
          row_d    = '0;
          row_ph_d = '0;
        end else begin
          row_d = row_q + RW'(1);
          if (row_q >= C_ROW_FIRST_EMIT) begin
            row_ph_d = (row_ph_q == C_PH_H_LAST) ? '0 : row_ph_q + PWH'(1);
          end else begin
            row_ph_d = '0;
          end
        end
      end else begin
        col_d = col_q + CW'(1);
        if (col_q >= C_COL_FIRST_EMIT) begin
          col_ph_d = (col_ph_q == C_PH_W_LAST) ? '0 : col_ph_q + PWW'(1);
        end else begin
          col_ph_d = '0;
        end
      end
    end
  end

  // Window shift: everything moves one column left, new column enters right.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < IN_WINDOW_H; r++) begin
        for (int c = 0; c < IN_WINDOW_W - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][IN_WINDOW_W-1] = col_src[r];
      end
    end
  end

  // Output handshake: a new emission wins over a clear.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_last_d  = is_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      col_ph_q    <= '0;
      row_ph_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      col_ph_q    <= col_ph_d;
      row_ph_q    <= row_ph_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Storage is data-only and deliberately not reset.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < IN_WINDOW_H - 1; k++) begin
        lb_mem[k][col_q] <= col_src[k+1];
      end
    end
  end

  generate
    for (genvar r = 0; r < IN_WINDOW_H; r++) begin : g_flat_row
      for (genvar c = 0; c < IN_WINDOW_W; c++) begin : g_flat_col
        assign window_flat[OUT_WIDTH-1-D*(r*IN_WINDOW_W+c) -: D] = win_q[r][c];
      end
    end
  endgenerate

  // The window registers only move on accept, and accept while a window is
  // pending either replaces it (emit) or retires it, so win_q is exactly the
  // emitted window whenever out_valid_q is set. Gating gives a zero output
  // out of reset without resetting the window array.
  assign window_out = out_valid_q ? window_flat : '0;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_window_buffer
// Purpose  : Directed self-checking bench for pe_window_buffer with a 6x6
//            frame of 8-bit pixels and a 4x4 window (3x3 filter, 2x2 pool).
//            Pixel value = frame base + row*6 + col.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_window_buffer;

  localparam int D     = 8;
  localparam int IMG_W = 6;
  localparam int IMG_H = 6;
  localparam int WH    = 4;
  localparam int WW    = 4;
  localparam int OW    = D * WH * WW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [D-1:0]  pixel_in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] window_out;
  logic          out_last;

  int checks = 0;
  int errors = 0;

  // Reference model state (position of next pixel, pending window).
  int            m_row, m_col;
  int            cur_base, frame_base0, frame_inc, frame_idx;
  logic          m_valid, m_last;
  logic [OW-1:0] m_win;
  int            acc_cnt, emit_cnt, fire_cnt, last_cnt, first_valid_at;
  logic [D-1:0]  fired_tl [$];
  logic [OW-1:0] saved;

  always #5 clk = ~clk;

  pe_window_buffer #(
    .D(D), .FH(3), .FW(3), .POOL_H(2), .POOL_W(2),
    .STRIDE_H(1), .STRIDE_W(1), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .window_out(window_out), .out_last(out_last)
  );

  function automatic logic [OW-1:0] exp_win(int base, int tr, int tc);
    logic [OW-1:0] w;
    w = '0;
    for (int r = 0; r < WH; r++)
      for (int c = 0; c < WW; c++)
        w[OW-1-D*(r*WW+c) -: D] = D'(base + (tr + r) * IMG_W + tc + c);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, compare at the falling edge, advance the model.
  task automatic step(input logic iv, input logic ordy);
    logic acc, emit;
    in_valid  = iv;
    out_ready = ordy;
    pixel_in  = D'(cur_base + m_row * IMG_W + m_col);
    @(negedge clk);
    chk("out_valid", OW'(out_valid), OW'(m_valid));
    if (m_valid) begin
      chk("window_out", window_out, m_win);
      chk("out_last", OW'(out_last), OW'(m_last));
    end
    chk("in_ready", OW'(in_ready), OW'(!m_valid || ordy));
    if (out_valid && first_valid_at < 0) first_valid_at = acc_cnt;
    if (m_valid && ordy) begin
      fire_cnt++;
      fired_tl.push_back(window_out[OW-1 -: D]);
      if (out_last) last_cnt++;
    end
    acc  = iv && (!m_valid || ordy);
    emit = acc && m_row >= WH - 1 && m_col >= WW - 1
        && ((m_row - (WH - 1)) % 2) == 0 && ((m_col - (WW - 1)) % 2) == 0;
    if (emit) begin
      m_win   = exp_win(cur_base, m_row - (WH - 1), m_col - (WW - 1));
      m_last  = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
      m_valid = 1'b1;
      emit_cnt++;
    end else if (ordy) begin
      m_valid = 1'b0;
      m_last  = 1'b0;
    end
    if (acc) begin
      acc_cnt++;
      if (m_col == IMG_W - 1) begin
        m_col = 0;
        if (m_row == IMG_H - 1) begin
          m_row = 0;
          frame_idx++;
          cur_base = frame_base0 + frame_idx * frame_inc;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int npix, input int pv, input int pr, input int budget);
    int target, cyc;
    target = acc_cnt + npix;
    cyc = 0;
    while (acc_cnt < target && cyc < budget) begin
      step($urandom_range(99) < pv, $urandom_range(99) < pr);
      cyc++;
    end
    chk("send_budget", OW'(acc_cnt), OW'(target));
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && m_valid; i++) step(1'b0, 1'b1);
    chk("drained", OW'(out_valid), OW'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pixel_in = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_row = 0; m_col = 0; m_valid = 1'b0; m_last = 1'b0;
    frame_idx = 0; cur_base = frame_base0;
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_out_last", OW'(out_last), OW'(0));
    chk("rst_window_out", window_out, '0);
    chk("rst_in_ready", OW'(in_ready), OW'(1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pixel_in = '0;
    frame_base0 = 0; frame_inc = 64;
    acc_cnt = 0; emit_cnt = 0; fire_cnt = 0; last_cnt = 0; first_valid_at = -1;
    do_reset();

    // First window appears one cycle after pixel 21 is accepted.
    send(22, 100, 100, 200);
    chk("first_valid", OW'(out_valid), OW'(1));
    chk("first_msb", OW'(window_out[OW-1 -: D]), OW'(0));
    chk("first_lsb", OW'(window_out[D-1:0]), OW'(21));
    chk("first_row1", OW'(window_out[OW-1-D*WW -: D]), OW'(6));
    chk("first_last", OW'(out_last), OW'(0));

    // Backpressure on the first window: held and no pixel taken.
    saved = window_out;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("bp_hold", window_out, saved);
    chk("bp_no_accept", OW'(acc_cnt), OW'(22));
    send(14, 100, 100, 200);
    drain();
    chk("f1_emits", OW'(emit_cnt), OW'(4));
    chk("f1_fires", OW'(fire_cnt), OW'(4));
    chk("f1_lasts", OW'(last_cnt), OW'(1));
    chk("f1_tl0", OW'(fired_tl[0]), OW'(0));
    chk("f1_tl1", OW'(fired_tl[1]), OW'(2));
    chk("f1_tl2", OW'(fired_tl[2]), OW'(12));
    chk("f1_tl3", OW'(fired_tl[3]), OW'(14));

    // Two back-to-back frames, second offset by 64.
    do_reset();
    fired_tl.delete(); emit_cnt = 0; fire_cnt = 0; last_cnt = 0;
    send(72, 100, 100, 300);
    drain();
    chk("b2b_fires", OW'(fire_cnt), OW'(8));
    chk("b2b_lasts", OW'(last_cnt), OW'(2));
    chk("b2b_f2_tl", OW'(fired_tl[4]), OW'(64));
    chk("b2b_f2_tl3", OW'(fired_tl[7]), OW'(78));

    // Reset mid-frame; pre-reset pixels carry different values.
    frame_base0 = 200;
    do_reset();
    send(20, 100, 100, 100);
    frame_base0 = 0;
    do_reset();
    acc_cnt = 0; first_valid_at = -1;
    send(21, 100, 100, 100);
    chk("mid_no_early", OW'(first_valid_at < 0), OW'(1));
    send(1, 100, 100, 10);
    chk("mid_valid", OW'(out_valid), OW'(1));
    chk("mid_msb", OW'(window_out[OW-1 -: D]), OW'(0));
    chk("mid_lsb", OW'(window_out[D-1:0]), OW'(21));

    // Random stalls on both sides over two frames.
    frame_base0 = 100; frame_inc = 50;
    do_reset();
    emit_cnt = 0; fire_cnt = 0;
    send(72, 50, 50, 3000);
    drain();
    chk("rnd_emits", OW'(emit_cnt), OW'(8));
    chk("rnd_fires", OW'(fire_cnt), OW'(8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
